// File: rtl/pe_sequencer.sv
// Sequences one pe_unit through a tile of output pixels: issues IFM/kernel
// buffer reads, tracks beats through the PE pipeline with a tag shift
// register, accumulates the two partial-sum lanes across channel tiles, and
// queues one result pair per pixel in a first-word-fall-through FIFO.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a command; nothing is being issued
// ISSUE  | one read beat per cycle unless a pixel's last beat lacks credit
// DRAIN  | all beats issued; waiting for the PE pipeline to empty
module pe_sequencer #(
   parameter int ADDR_W    = 10,
   parameter int PE_LAT    = 4,
   parameter int ACC_W     = 28,
   parameter int OUT_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_mode,
   input  logic [7:0]        cmd_ctiles,
   input  logic [7:0]        cmd_npix,
   input  logic [ADDR_W-1:0] cmd_ifm_base,
   input  logic [ADDR_W-1:0] cmd_krn_base,
   output logic              ifm_rd_en,
   output logic [ADDR_W-1:0] ifm_rd_addr,
   output logic              krn_rd_en,
   output logic [ADDR_W-1:0] krn_rd_addr,
   output logic [1:0]        pe_mode,
   input  logic [19:0]       pe_ofm0,
   input  logic [19:0]       pe_ofm1,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data0,
   output logic [ACC_W-1:0]  out_data1,
   output logic              out_last,
   output logic              busy
);

   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CNT_W = $clog2(OUT_DEPTH + PE_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t             state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic [7:0]         ctiles_q, ctiles_d;
   logic [7:0]         npix_q, npix_d;
   logic [7:0]         ct_q, ct_d;
   logic [7:0]         pix_q, pix_d;
   logic [ADDR_W-1:0]  ifm_addr_q, ifm_addr_d;
   logic [ADDR_W-1:0]  krn_addr_q, krn_addr_d;
   logic [ADDR_W-1:0]  krn_base_q, krn_base_d;

   // tag bits: [3] valid, [2] first tile, [1] last tile, [0] final pixel
   logic [3:0]         tag_q [PE_LAT];
   logic [3:0]         head;

   logic [ACC_W-1:0]   acc0_q, acc1_q;
   logic signed [19:0] ofm0_s, ofm1_s;
   logic [ACC_W-1:0]   ext0, ext1, sum0, sum1;

   logic [ACC_W-1:0]   mem0 [OUT_DEPTH];
   logic [ACC_W-1:0]   mem1 [OUT_DEPTH];
   logic               meml [OUT_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               beat_last, pix_last, credit_ok, issue, push, pop, pipe_busy;
   logic [CNT_W-1:0]   inflight;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign beat_last = (ct_q == ctiles_q - 8'd1);
   assign pix_last  = (pix_q == npix_q - 8'd1);
   assign head      = tag_q[PE_LAT-1];

   // In-flight last beats each hold a reserved FIFO slot until they push.
   always_comb begin
      inflight  = '0;
      pipe_busy = 1'b0;
      for (int i = 0; i < PE_LAT; i++) begin
         inflight  = inflight + CNT_W'(tag_q[i][3] & tag_q[i][1]);
         pipe_busy = pipe_busy | tag_q[i][3];
      end
   end

   assign credit_ok = (cnt_q + inflight) < CNT_W'(OUT_DEPTH);
   assign issue     = (state_q == S_ISSUE) && (!beat_last || credit_ok);

   // Next-state logic: command latch, beat issue and address stepping.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      ctiles_d   = ctiles_q;
      npix_d     = npix_q;
      ct_d       = ct_q;
      pix_d      = pix_q;
      ifm_addr_d = ifm_addr_q;
      krn_addr_d = krn_addr_q;
      krn_base_d = krn_base_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               mode_d     = cmd_mode;
               ctiles_d   = (cmd_ctiles == 8'd0) ? 8'd1 : cmd_ctiles;
               npix_d     = cmd_npix;
               ct_d       = 8'd0;
               pix_d      = 8'd0;
               ifm_addr_d = cmd_ifm_base;
               krn_addr_d = cmd_krn_base;
               krn_base_d = cmd_krn_base;
               state_d    = (cmd_npix == 8'd0) ? S_DRAIN : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (issue) begin
               // IFM pixels are stored back to back, so its address is linear.
               ifm_addr_d = ifm_addr_q + ADDR_W'(1);
               if (beat_last) begin
                  ct_d       = 8'd0;
                  pix_d      = pix_q + 8'd1;
                  krn_addr_d = krn_base_q;
                  if (pix_last) state_d = S_DRAIN;
               end else begin
                  ct_d       = ct_q + 8'd1;
                  krn_addr_d = krn_addr_q + ADDR_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (!pipe_busy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mode_q     <= '0;
         ctiles_q   <= 8'd1;
         npix_q     <= '0;
         ct_q       <= '0;
         pix_q      <= '0;
         ifm_addr_q <= '0;
         krn_addr_q <= '0;
         krn_base_q <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         ctiles_q   <= ctiles_d;
         npix_q     <= npix_d;
         ct_q       <= ct_d;
         pix_q      <= pix_d;
         ifm_addr_q <= ifm_addr_d;
         krn_addr_q <= krn_addr_d;
         krn_base_q <= krn_base_d;
      end
   end

   // Tag pipeline aligned with the PE data path.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PE_LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= {issue, ct_q == 8'd0, beat_last, beat_last && pix_last};
         for (int i = 1; i < PE_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign ofm0_s = pe_ofm0;
   assign ofm1_s = pe_ofm1;
   assign ext0   = ACC_W'(ofm0_s);
   assign ext1   = ACC_W'(ofm1_s);
   assign sum0   = head[2] ? ext0 : acc0_q + ext0;
   assign sum1   = head[2] ? ext1 : acc1_q + ext1;
   assign push   = head[3] & head[1];
   assign pop    = out_valid & out_ready;

   // Channel-tile accumulators.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc0_q <= '0;
         acc1_q <= '0;
      end else if (head[3]) begin
         acc0_q <= sum0;
         acc1_q <= sum1;
      end
   end

   // FIFO storage; contents are invalidated by the pointers, not cleared.
   always_ff @(posedge clk) begin
      if (push) begin
         mem0[wr_ptr_q] <= sum0;
         mem1[wr_ptr_q] <= sum1;
         meml[wr_ptr_q] <= head[0];
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign cmd_ready   = (state_q == S_IDLE);
   assign ifm_rd_en   = issue;
   assign krn_rd_en   = issue;
   assign ifm_rd_addr = ifm_addr_q;
   assign krn_rd_addr = krn_addr_q;
   assign pe_mode     = mode_q;
   assign out_valid   = (cnt_q != '0);
   assign out_data0   = out_valid ? mem0[rd_ptr_q] : '0;
   assign out_data1   = out_valid ? mem1[rd_ptr_q] : '0;
   assign out_last    = out_valid ? meml[rd_ptr_q] : 1'b0;
   assign busy        = (state_q != S_IDLE) || out_valid;

endmodule

// File: tb/tb_pe_sequencer.sv
// Bench for pe_sequencer: a delay-line PE model answers each read beat
// PE_LAT cycles later; a table of commands with hand-computed results is
// replayed, followed by back-pressure, reset-abort and empty-command cases.
module tb_pe_sequencer;

   localparam int PE_LAT    = 4;
   localparam int OUT_DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [1:0]  cmd_mode;
   logic [7:0]  cmd_ctiles, cmd_npix;
   logic [9:0]  cmd_ifm_base, cmd_krn_base;
   logic        out_ready;
   logic [19:0] pe_ofm0, pe_ofm1;

   logic        cmd_ready, ifm_rd_en, krn_rd_en, out_valid, out_last, busy;
   logic [9:0]  ifm_rd_addr, krn_rd_addr;
   logic [1:0]  pe_mode;
   logic [27:0] out_data0, out_data1;

   logic        d2_cmd_ready, d2_ifm_rd_en, d2_krn_rd_en, d2_out_valid, d2_out_last, d2_busy;
   logic [9:0]  d2_ifm_rd_addr, d2_krn_rd_addr;
   logic [1:0]  d2_pe_mode;
   logic [19:0] d2_out_data0, d2_out_data1;

   pe_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_ctiles(cmd_ctiles), .cmd_npix(cmd_npix),
      .cmd_ifm_base(cmd_ifm_base), .cmd_krn_base(cmd_krn_base),
      .ifm_rd_en(ifm_rd_en), .ifm_rd_addr(ifm_rd_addr),
      .krn_rd_en(krn_rd_en), .krn_rd_addr(krn_rd_addr), .pe_mode(pe_mode),
      .pe_ofm0(pe_ofm0), .pe_ofm1(pe_ofm1), .out_valid(out_valid),
      .out_ready(out_ready), .out_data0(out_data0), .out_data1(out_data1),
      .out_last(out_last), .busy(busy));

   pe_sequencer #(.ACC_W(20)) dut20 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(d2_cmd_ready),
      .cmd_mode(cmd_mode), .cmd_ctiles(cmd_ctiles), .cmd_npix(cmd_npix),
      .cmd_ifm_base(cmd_ifm_base), .cmd_krn_base(cmd_krn_base),
      .ifm_rd_en(d2_ifm_rd_en), .ifm_rd_addr(d2_ifm_rd_addr),
      .krn_rd_en(d2_krn_rd_en), .krn_rd_addr(d2_krn_rd_addr), .pe_mode(d2_pe_mode),
      .pe_ofm0(pe_ofm0), .pe_ofm1(pe_ofm1), .out_valid(d2_out_valid),
      .out_ready(out_ready), .out_data0(d2_out_data0), .out_data1(d2_out_data1),
      .out_last(d2_out_last), .busy(d2_busy));

   always #5 clk = ~clk;

   // PE model: beat value is its index+1 within the command, or saturated.
   logic        pe_sel;
   logic [19:0] beat_idx;
   logic [19:0] dl0 [PE_LAT];
   logic [19:0] dl1 [PE_LAT];
   int          cyc;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cmd_valid && cmd_ready) beat_idx <= 20'd0;
      else if (ifm_rd_en)         beat_idx <= beat_idx + 20'd1;
      dl0[0] <= ifm_rd_en ? (pe_sel ? 20'h7FFFF : beat_idx + 20'd1) : 20'h0;
      dl1[0] <= 20'hFFFFF;
      for (int i = 1; i < PE_LAT; i++) begin
         dl0[i] <= dl0[i-1];
         dl1[i] <= dl1[i-1];
      end
   end
   assign pe_ofm0 = dl0[PE_LAT-1];
   assign pe_ofm1 = dl1[PE_LAT-1];

   // Monitor: records read beats and accepted results (only writer of these).
   logic [9:0]  ifm_q[$], krn_q[$];
   int          rc_q[$];
   logic [27:0] r0[$], r1[$];
   logic        rl[$];
   logic [19:0] r20[$];
   int          rd_cnt, en_mis, v2_mis;

   always @(negedge clk) begin
      if (ifm_rd_en) begin
         ifm_q.push_back(ifm_rd_addr);
         krn_q.push_back(krn_rd_addr);
         rc_q.push_back(cyc);
         rd_cnt <= rd_cnt + 1;
      end
      if (krn_rd_en !== ifm_rd_en) en_mis <= en_mis + 1;
      if ({d2_cmd_ready, d2_ifm_rd_en, d2_krn_rd_en, d2_ifm_rd_addr, d2_krn_rd_addr,
           d2_pe_mode, d2_out_valid, d2_out_last, d2_busy, d2_out_data1} !==
          {cmd_ready, ifm_rd_en, krn_rd_en, ifm_rd_addr, krn_rd_addr,
           pe_mode, out_valid, out_last, busy, out_data1[19:0]})
         v2_mis <= v2_mis + 1;
      if (out_valid && out_ready) begin
         r0.push_back(out_data0);
         r1.push_back(out_data1);
         rl.push_back(out_last);
         r20.push_back(d2_out_data0);
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_cmd(input logic [1:0] m, input logic [7:0] ct, input logic [7:0] np,
                           input logic [9:0] ib, input logic [9:0] kb);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      cmd_mode = m; cmd_ctiles = ct; cmd_npix = np;
      cmd_ifm_base = ib; cmd_krn_base = kb; cmd_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (!ok) chk("cmd_accept_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int maxc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (!busy && !out_valid) begin ok = 1'b1; break; end
      end
      if (!ok) chk("idle_timeout", 0, 1);
   endtask

   typedef struct {
      logic [1:0]       mode;
      logic [7:0]       ctiles;
      logic [7:0]       npix;
      logic [9:0]       ifm;
      logic [9:0]       krn;
      logic             sel;
      int               nres;
      logic [3:0][27:0] e0;
      logic [3:0][27:0] e1;
      logic [3:0]       el;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int rb, qb, cte, nrd, eb, vb;
      logic [27:0] hold;
      logic [9:0]  ea;

      vecs[0] = '{2'd1, 8'd3, 8'd2, 10'h010, 10'h020, 1'b0, 2,
                  {28'd0, 28'd0, 28'd15, 28'd6},
                  {28'd0, 28'd0, 28'hFFFFFFD, 28'hFFFFFFD}, 4'b0010};
      vecs[1] = '{2'd2, 8'd0, 8'd1, 10'h100, 10'h200, 1'b1, 1,
                  {28'd0, 28'd0, 28'd0, 28'h007FFFF},
                  {28'd0, 28'd0, 28'd0, 28'hFFFFFFF}, 4'b0001};
      vecs[2] = '{2'd3, 8'd2, 8'd1, 10'h000, 10'h000, 1'b1, 1,
                  {28'd0, 28'd0, 28'd0, 28'h00FFFFE},
                  {28'd0, 28'd0, 28'd0, 28'hFFFFFFE}, 4'b0001};
      vecs[3] = '{2'd0, 8'd1, 8'd3, 10'h3FE, 10'h005, 1'b0, 3,
                  {28'd0, 28'd3, 28'd2, 28'd1},
                  {28'd0, 28'hFFFFFFF, 28'hFFFFFFF, 28'hFFFFFFF}, 4'b0100};
      vecs[4] = '{2'd1, 8'd4, 8'd1, 10'h050, 10'h060, 1'b0, 1,
                  {28'd0, 28'd0, 28'd0, 28'd10},
                  {28'd0, 28'd0, 28'd0, 28'hFFFFFFC}, 4'b0001};

      rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_ctiles = '0; cmd_npix = '0;
      cmd_ifm_base = '0; cmd_krn_base = '0; out_ready = 1'b1; pe_sel = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", ifm_rd_en, 0);
      chk("rst_pe_mode", pe_mode, 0);
      chk("rst_ifm_addr", ifm_rd_addr, 0);
      chk("rst_out_data0", out_data0, 0);
      @(posedge clk); #1 rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         rb = rd_cnt; qb = r0.size();
         pe_sel = vecs[v].sel;
         send_cmd(vecs[v].mode, vecs[v].ctiles, vecs[v].npix, vecs[v].ifm, vecs[v].krn);
         @(negedge clk);
         chk("pe_mode", pe_mode, vecs[v].mode);
         wait_idle(400);
         cte = (vecs[v].ctiles == 0) ? 1 : vecs[v].ctiles;
         nrd = cte * vecs[v].npix;
         chk("read_count", rd_cnt - rb, nrd);
         if (rd_cnt - rb == nrd && nrd > 0) begin
            chk("read_contiguous", rc_q[rb + nrd - 1] - rc_q[rb] + 1, nrd);
            for (int k = 0; k < nrd; k++) begin
               ea = vecs[v].ifm + 10'(k);
               chk("ifm_addr", ifm_q[rb + k], ea);
               ea = vecs[v].krn + 10'(k % cte);
               chk("krn_addr", krn_q[rb + k], ea);
            end
         end
         chk("result_count", r0.size() - qb, vecs[v].nres);
         if (r0.size() - qb == vecs[v].nres) begin
            for (int i = 0; i < vecs[v].nres; i++) begin
               chk("out_data0", r0[qb + i], vecs[v].e0[i]);
               chk("out_data1", r1[qb + i], vecs[v].e1[i]);
               chk("out_last", rl[qb + i], vecs[v].el[i]);
               chk("acc20_data0", r20[qb + i], vecs[v].e0[i][19:0]);
            end
         end
      end

      // Back-pressure: only OUT_DEPTH results may be issued while stalled.
      rb = rd_cnt; qb = r0.size();
      pe_sel = 1'b0;
      @(posedge clk); #1 out_ready = 1'b0;
      send_cmd(2'd0, 8'd1, 8'd20, 10'h000, 10'h100);
      repeat (60) @(negedge clk);
      chk("stall_reads", rd_cnt - rb, OUT_DEPTH);
      chk("stall_valid", out_valid, 1);
      chk("stall_data0", out_data0, 1);
      hold = out_data0;
      repeat (5) @(negedge clk);
      chk("stall_hold_data0", out_data0, 1);
      chk("stall_hold_last", out_last, 0);
      chk("stall_reads_held", rd_cnt - rb, OUT_DEPTH);
      chk("stall_busy", busy, 1);
      @(posedge clk); #1 out_ready = 1'b1;
      wait_idle(600);
      chk("stall_result_count", r0.size() - qb, 20);
      if (r0.size() - qb == 20) begin
         for (int i = 0; i < 20; i++) begin
            chk("stall_data0_order", r0[qb + i], i + 1);
            chk("stall_last", rl[qb + i], (i == 19));
         end
      end

      // Reset in the middle of a command with results waiting in the FIFO.
      @(posedge clk); #1 out_ready = 1'b0;
      send_cmd(2'd1, 8'd2, 8'd10, 10'h080, 10'h090);
      repeat (12) @(negedge clk);
      chk("abort_pre_valid", out_valid, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_cmd_ready", cmd_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_rd_en", ifm_rd_en, 0);
      out_ready = 1'b1;
      qb = r0.size();
      send_cmd(2'd2, 8'd2, 8'd2, 10'h000, 10'h000);
      wait_idle(400);
      chk("post_abort_count", r0.size() - qb, 2);
      if (r0.size() - qb == 2) begin
         chk("post_abort_d0_0", r0[qb], 3);
         chk("post_abort_d0_1", r0[qb + 1], 7);
         chk("post_abort_d1_0", r1[qb], 28'hFFFFFFE);
         chk("post_abort_last_0", rl[qb], 0);
         chk("post_abort_last_1", rl[qb + 1], 1);
      end

      // Empty command.
      rb = rd_cnt; qb = r0.size();
      send_cmd(2'd3, 8'd5, 8'd0, 10'h000, 10'h000);
      @(negedge clk);
      @(negedge clk);
      chk("npix0_cmd_ready", cmd_ready, 1);
      chk("npix0_pe_mode", pe_mode, 3);
      repeat (5) @(negedge clk);
      chk("npix0_reads", rd_cnt - rb, 0);
      chk("npix0_results", r0.size() - qb, 0);
      chk("npix0_out_valid", out_valid, 0);

      eb = en_mis; vb = v2_mis;
      chk("krn_en_tracks_ifm_en", eb, 0);
      chk("acc20_instance_match", vb, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      cyc = 0; rd_cnt = 0; en_mis = 0; v2_mis = 0; beat_idx = '0;
      for (int i = 0; i < PE_LAT; i++) begin dl0[i] = '0; dl1[i] = '0; end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
